// File: rtl/peak_decide.sv
// rtl/peak_decide.sv - frame-end peak dominance decision with valid/ready verdict and tracker clear
module peak_decide #(
    parameter int unsigned              THR_NUM   = 3,
    parameter int unsigned              THR_SHIFT = 1,
    parameter logic signed [20:0]       ABS_THR   = 21'sd1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [20:0] xl_in,
    input  logic signed [20:0] xs_in,
    input  logic               kt_in,
    input  logic               single_in,
    input  logic               frame_end,
    input  logic               out_ready,
    output logic               clr_out,
    output logic               busy,
    output logic               dec_valid,
    output logic               dec_hit,
    output logic               dec_empty,
    output logic signed [20:0] dec_peak,
    output logic signed [27:0] dec_margin,
    output logic               dropped
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MULT  = 3'd1,
        CMP   = 3'd2,
        OUT   = 3'd3,
        CLEAR = 3'd4
    } state_t;

    localparam logic [3:0] THR_BITS  = 4'(THR_NUM);
    localparam logic [1:0] SHIFT_AMT = 2'(THR_SHIFT);

    state_t              state, state_next;
    logic signed [20:0]  xl_r, xs_r;
    logic                single_r;
    logic [1:0]          bit_idx;
    logic signed [27:0]  acc;

    logic signed [27:0]  xl_ext, xs_ext, abs_ext;
    logic signed [27:0]  partial, margin;

    assign xl_ext  = {{7{xl_r[20]}}, xl_r};
    assign xs_ext  = {{7{xs_r[20]}}, xs_r};
    assign abs_ext = {{7{ABS_THR[20]}}, ABS_THR};

    // One shift-add step of THR_NUM * xs per MULT cycle, LSB first.
    assign partial = THR_BITS[bit_idx] ? (xs_ext <<< bit_idx) : 28'sd0;

    always_comb begin
        margin = '0;
        if (single_r)
            margin = xl_ext - abs_ext;
        else
            margin = (xl_ext <<< SHIFT_AMT) - acc;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (frame_end) begin
                    if (kt_in)
                        state_next = OUT;
                    else if (single_in)
                        state_next = CMP;
                    else
                        state_next = MULT;
                end
            end
            MULT:  if (bit_idx == 2'd3) state_next = CMP;
            CMP:   state_next = OUT;
            OUT:   if (out_ready) state_next = CLEAR;
            CLEAR: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign dec_valid = (state == OUT);
    assign clr_out   = (state == CLEAR);

    always_ff @(posedge clk) begin
        if (reset) begin
            xl_r       <= '0;
            xs_r       <= '0;
            single_r   <= 1'b0;
            bit_idx    <= 2'd0;
            acc        <= '0;
            dec_hit    <= 1'b0;
            dec_empty  <= 1'b0;
            dec_peak   <= '0;
            dec_margin <= '0;
            dropped    <= 1'b0;
        end else begin
            if (frame_end && state != IDLE)
                dropped <= 1'b1;

            case (state)
                IDLE: begin
                    if (frame_end) begin
                        xl_r     <= xl_in;
                        xs_r     <= xs_in;
                        single_r <= single_in;
                        acc      <= '0;
                        bit_idx  <= 2'd0;
                        // An empty frame skips the arithmetic and publishes its verdict directly.
                        if (kt_in) begin
                            dec_empty  <= 1'b1;
                            dec_hit    <= 1'b0;
                            dec_margin <= '0;
                            dec_peak   <= xl_in;
                        end
                    end
                end
                MULT: begin
                    acc     <= acc + partial;
                    bit_idx <= bit_idx + 2'd1;
                end
                CMP: begin
                    dec_margin <= margin;
                    dec_hit    <= ~margin[27];
                    dec_empty  <= 1'b0;
                    dec_peak   <= xl_r;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_peak_decide.sv
// tb/tb_peak_decide.sv - scoreboard bench for peak_decide
module tb_peak_decide;

    localparam int NUM   = 3;
    localparam int SHIFT = 1;
    localparam int ABS   = 1000;

    typedef struct {
        logic               hit;
        logic               empty;
        logic signed [27:0] margin;
        logic signed [20:0] peak;
        int                 lat;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [20:0] xl_in, xs_in;
    logic               kt_in, single_in, frame_end, out_ready;
    logic               clr_out, busy, dec_valid, dec_hit, dec_empty, dropped;
    logic signed [20:0] dec_peak;
    logic signed [27:0] dec_margin;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    peak_decide dut (
        .clk        (clk),
        .reset      (reset),
        .xl_in      (xl_in),
        .xs_in      (xs_in),
        .kt_in      (kt_in),
        .single_in  (single_in),
        .frame_end  (frame_end),
        .out_ready  (out_ready),
        .clr_out    (clr_out),
        .busy       (busy),
        .dec_valid  (dec_valid),
        .dec_hit    (dec_hit),
        .dec_empty  (dec_empty),
        .dec_peak   (dec_peak),
        .dec_margin (dec_margin),
        .dropped    (dropped)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic signed [20:0] xl, input logic signed [20:0] xs,
                                   input logic kt, input logic sng);
        exp_t e;
        int   m;
        e.peak = xl;
        if (kt) begin
            m = 0; e.empty = 1'b1; e.lat = 1;
        end else if (sng) begin
            m = int'(xl) - ABS; e.empty = 1'b0; e.lat = 2;
        end else begin
            m = int'(xl) * (2 ** SHIFT) - int'(xs) * NUM; e.empty = 1'b0; e.lat = 6;
        end
        e.margin = 28'(m);
        e.hit    = !kt && (m >= 0);
        return e;
    endfunction

    // Drives a frame in the current cycle and follows it through acceptance; returns two cycles after acceptance.
    task automatic run_frame(input logic signed [20:0] xl, input logic signed [20:0] xs,
                             input logic kt, input logic sng, input string tag);
        exp_t e;
        int   cyc;
        sb.push_back(model(xl, xs, kt, sng));
        out_ready = 1'b1;
        xl_in = xl; xs_in = xs; kt_in = kt; single_in = sng; frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        cyc = 1;
        while (!dec_valid && cyc < 40) begin
            step();
            cyc++;
        end
        e = sb.pop_front();
        checks++; if (cyc !== e.lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", tag, cyc, e.lat); end
        checks++; if (dec_hit !== e.hit) begin errors++; $display("FAIL %s hit: got %b want %b", tag, dec_hit, e.hit); end
        checks++; if (dec_empty !== e.empty) begin errors++; $display("FAIL %s empty: got %b want %b", tag, dec_empty, e.empty); end
        checks++; if (dec_margin !== e.margin) begin errors++; $display("FAIL %s margin: got %0d want %0d", tag, dec_margin, e.margin); end
        if (!kt) begin
            checks++; if (dec_peak !== e.peak) begin errors++; $display("FAIL %s peak: got %0d want %0d", tag, dec_peak, e.peak); end
        end
        step();
        checks++; if (clr_out !== 1'b1 || dec_valid !== 1'b0) begin errors++; $display("FAIL %s clear: clr_out=%b dec_valid=%b want 1/0", tag, clr_out, dec_valid); end
        step();
        checks++; if (busy !== 1'b0 || clr_out !== 1'b0) begin errors++; $display("FAIL %s idle: busy=%b clr_out=%b want 0/0", tag, busy, clr_out); end
    endtask

    task automatic test_reset();
        reset = 1'b1; frame_end = 1'b0; out_ready = 1'b0;
        xl_in = '0; xs_in = '0; kt_in = 1'b0; single_in = 1'b0;
        step(); step();
        reset = 1'b0;
        checks++;
        if ({busy, dec_valid, clr_out, dec_hit, dec_empty, dropped} !== 6'b0 || dec_peak !== 21'sd0 || dec_margin !== 28'sd0) begin
            errors++;
            $display("FAIL reset: busy=%b valid=%b clr=%b hit=%b empty=%b dropped=%b peak=%0d margin=%0d want all 0",
                     busy, dec_valid, clr_out, dec_hit, dec_empty, dropped, dec_peak, dec_margin);
        end
    endtask

    task automatic test_dual();
        run_frame(21'sd300, 21'sd200, 1'b0, 1'b0, "dual_eq");
        run_frame(21'sd299, 21'sd200, 1'b0, 1'b0, "dual_below");
        run_frame(-21'sd10, -21'sd20, 1'b0, 1'b0, "dual_neg");
        run_frame(21'sd1048575, -21'sd1048576, 1'b0, 1'b0, "dual_extreme");
    endtask

    task automatic test_single();
        run_frame(21'sd999, 21'sd5, 1'b0, 1'b1, "single_999");
        run_frame(21'sd1000, 21'sd5, 1'b0, 1'b1, "single_1000");
    endtask

    task automatic test_empty();
        run_frame(21'h100000, 21'h100000, 1'b1, 1'b0, "empty");
    endtask

    task automatic test_stall();
        exp_t e;
        int   cyc;
        sb.push_back(model(21'sd500, 21'sd100, 1'b0, 1'b0));
        out_ready = 1'b0;
        xl_in = 21'sd500; xs_in = 21'sd100; kt_in = 1'b0; single_in = 1'b0; frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        cyc = 1;
        while (!dec_valid && cyc < 40) begin step(); cyc++; end
        e = sb.pop_front();
        checks++; if (cyc !== e.lat) begin errors++; $display("FAIL stall latency: got %0d want %0d", cyc, e.lat); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (dec_valid !== 1'b1 || clr_out !== 1'b0 || dec_margin !== e.margin || dec_hit !== e.hit || dec_peak !== e.peak) begin
                errors++;
                $display("FAIL stall hold %0d: valid=%b clr=%b margin=%0d hit=%b peak=%0d want 1/0/%0d/%b/%0d",
                         i, dec_valid, clr_out, dec_margin, dec_hit, dec_peak, e.margin, e.hit, e.peak);
            end
            frame_end = (i == 3);
            xl_in = 21'sd7;
            step();
        end
        frame_end = 1'b0;
        checks++; if (dropped !== 1'b1) begin errors++; $display("FAIL stall dropped: got %b want 1", dropped); end
        out_ready = 1'b1;
        step();
        checks++; if (clr_out !== 1'b1) begin errors++; $display("FAIL stall clear: got %b want 1", clr_out); end
        step();
        checks++; if (dropped !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL stall sticky: dropped=%b busy=%b want 1/0", dropped, busy); end
    endtask

    task automatic test_midreset();
        out_ready = 1'b1;
        xl_in = 21'sd400; xs_in = 21'sd100; kt_in = 1'b0; single_in = 1'b0; frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({busy, dec_valid, clr_out, dec_hit, dec_empty, dropped} !== 6'b0 || dec_peak !== 21'sd0 || dec_margin !== 28'sd0) begin
            errors++;
            $display("FAIL midreset: busy=%b valid=%b clr=%b hit=%b empty=%b dropped=%b peak=%0d margin=%0d want all 0",
                     busy, dec_valid, clr_out, dec_hit, dec_empty, dropped, dec_peak, dec_margin);
        end
        step();
        checks++; if (clr_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset after: clr=%b busy=%b want 0/0", clr_out, busy); end
        run_frame(21'sd400, 21'sd100, 1'b0, 1'b0, "post_reset");
    endtask

    task automatic test_back_to_back();
        run_frame(21'sd50, 21'sd40, 1'b0, 1'b0, "b2b_0");
        run_frame(-21'sd2000, 21'sd0, 1'b0, 1'b1, "b2b_1");
        run_frame(21'sd0, 21'sd0, 1'b1, 1'b0, "b2b_2");
        for (int i = 0; i < 4; i++) begin
            logic signed [20:0] a, b;
            a = 21'($urandom_range(0, 4000)) - 21'sd2000;
            b = 21'($urandom_range(0, 4000)) - 21'sd2000;
            run_frame(a, b, 1'b0, i[0], "b2b_rand");
        end
        checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL b2b dropped: got %b want 0", dropped); end
    endtask

    initial begin
        test_reset();
        test_dual();
        test_single();
        test_empty();
        test_stall();
        test_midreset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/peak_decide.md
# peak_decide

Decision stage directly downstream of the largest/second-largest tracking register. At each frame end it latches the tracked peak (`xl_in`) and runner-up (`xs_in`). It then runs a ratio-dominance test using shift-add multiplication and presents the verdict on a valid/ready output. After the verdict is accepted, it pulses `clr_out` to re-arm the tracker for the next frame.

## Interface
Parameters:
- `THR_NUM`, 3: 4-bit unsigned numerator of the dominance ratio (0..15).
- `THR_SHIFT`, 1: left-shift applied to the peak, giving ratio = THR_NUM / 2^THR_SHIFT (0..3).
- `ABS_THR`, 21'sd1000: signed absolute threshold used in single mode.

Ports:
- `clk`  in  1  — the block's single clock.
- `reset`  in  1  — synchronous, active-high reset, sampled on the rising edge of `clk`.
- `xl_in`  in  21  — tracked largest value, signed two's complement. 21'h100000 means "empty".
- `xs_in`  in  21  — tracked second-largest value, same encoding as `xl_in`.
- `kt_in`  in  1  — 1 means no value has been written to the tracker since its last clear.
- `single_in`  in  1  — tracker is in single-value mode; `xs_in` is ignored.
- `frame_end`  in  1  — one-cycle pulse: the last candidate of the frame is already in the tracker.
- `out_ready`  in  1  — downstream accepts the verdict.
- `clr_out`  out  1  — one-cycle clear pulse to the tracker.
- `busy`  out  1  — high whenever the state is not IDLE.
- `dec_valid`  out  1  — verdict valid.
- `dec_hit`  out  1  — peak passes the test.
- `dec_empty`  out  1  — frame contained no candidates.
- `dec_peak`  out  21  — latched `xl_in`.
- `dec_margin`  out  28  — signed test margin.
- `dropped`  out  1  — sticky: a `frame_end` arrived while busy.

## Operation
- States: IDLE, MULT, CMP, OUT, CLEAR.
- IDLE
  - On `frame_end`=1, latch `xl_in`, `xs_in`, `kt_in` and `single_in`.
  - If `kt_in`=1, go to OUT with `dec_empty`=1, `dec_hit`=0, `dec_margin`=0.
  - Else if `single_in`=1, go to CMP.
  - Else go to MULT with `acc`=0 and bit index 0.
- MULT: 4 cycles, LSB first.
  - Each cycle: if THR_NUM[i]=1, `acc += sext28(xs) <<< i`.
  - After i=3, go to CMP.
- CMP: 1 cycle, then go to OUT.
  - Dual mode: `margin = (sext28(xl) <<< THR_SHIFT) − acc`.
  - Single mode: `margin = sext28(xl) − sext28(ABS_THR)`.
  - `dec_hit` = (margin ≥ 0), signed comparison.
- OUT
  - `dec_valid`=1; all `dec_*` outputs are held stable until `out_ready`=1.
  - On `dec_valid` & `out_ready`, go to CLEAR.
- CLEAR: `clr_out`=1 for exactly one cycle, then go to IDLE.
- All arithmetic is 28-bit signed with no saturation. The worst case, 15·|−2^20|·… and 2^20·8, fits in 28 bits.
- `frame_end` in any state other than IDLE is ignored and sets `dropped`=1. `dropped` clears only on reset.
- The sentinel 21'h100000 is never treated specially by the arithmetic. Emptiness is determined solely by `kt_in`.

## Timing
- Reset values: state IDLE, `clr_out`=0, `busy`=0, `dec_valid`=0, `dec_hit`=0, `dec_empty`=0, `dec_peak`=0, `dec_margin`=0, `dropped`=0, `acc`=0.
- Reset asserted in any state, including mid-MULT or during OUT, returns everything to reset values on the next edge. No `clr_out` pulse is emitted.
- Latency, with `frame_end` sampled in cycle t:
  - Dual mode: MULT during t+1..t+4, CMP at t+5, `dec_valid`=1 from t+6.
  - Single mode: CMP at t+1, `dec_valid` from t+2.
  - Empty frame: `dec_valid` from t+1.
- Handshake accepted in cycle a:
  - `dec_valid`=0 and `clr_out`=1 at a+1.
  - IDLE at a+2.
  - A `frame_end` at a+2 is accepted.
- `out_ready` may be high before `dec_valid`; acceptance happens in the first OUT cycle.
- A `frame_end` coinciding with the CLEAR cycle sets `dropped`.
- `busy` is combinational from state: 1 for MULT, CMP, OUT and CLEAR.
- All `dec_*` outputs keep their last values after acceptance, until the next CMP or empty capture.

## Test plan
- Defaults, dual mode, xl=300, xs=200, kt=0, `frame_end` at t, `out_ready`=1 → `dec_valid` at t+6, `dec_hit`=1, margin=0, `dec_peak`=300; `clr_out` at t+7.
- Dual mode, xl=299, xs=200 → `dec_hit`=0, margin=−2. Also xl=−10, xs=−20 → 600-style check: margin=−20+60=40, `dec_hit`=1.
- Single mode, xl=999 → `dec_valid` at t+2, `dec_hit`=0, margin=−1. Then xl=1000 → `dec_hit`=1, margin=0.
- kt=1 at `frame_end` → `dec_valid` at t+1, `dec_empty`=1, `dec_hit`=0; `clr_out` still pulses after acceptance.
- `out_ready` held 0 for 10 cycles in OUT → outputs stable, no `clr_out`. A `frame_end` during the stall sets `dropped`=1, which persists after acceptance.
- Reset at t+3 of a dual-mode frame → all outputs at reset values at t+4, no `clr_out`. The next `frame_end` is processed normally.
